// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Recovers the division ratio of a divided or slow clock by measuring the
//   high and low phase lengths of sig_in in cycles of clk. It reports phase
//   and period counts, a lock flag and a stall timeout.
//
//   Optional feature macro: CLK_MEAS_FILTER_EN
//     When defined, the synchronised input passes through a FILT_LEN-deep
//     agreement filter before edge detection (pulses shorter than FILT_LEN
//     cycles are ignored, latency grows by FILT_LEN cycles).
//
// Ports
//   clk         in   1        system clock, rising edge
//   reset       in   1        asynchronous, active-low, clears all state
//   sig_in      in   1        measured signal, may be asynchronous to clk
//   high_cnt    out  CNT_W    last complete high-phase length (clk cycles)
//   low_cnt     out  CNT_W    last complete low-phase length (clk cycles)
//   period      out  CNT_W+1  high_cnt + low_cnt, updated with meas_valid
//   meas_valid  out  1        one-cycle pulse: new period available
//   locked      out  1        LOCK_N consecutive identical periods seen
//   timeout     out  1        no sig_in edge for MAX_CNT cycles
//
// FSM states
//   state | meaning
//   IDLE  | waiting for the first edge; the partial phase before it is dropped
//   PH1   | one edge seen, the next edge closes the first full phase
//   PH2   | one phase captured, the next edge closes the other and reports
//   RUN   | steady state: fall updates high_cnt, rise updates low_cnt + period
module clk_period_meter #(
  parameter int MAX_CNT  = 1024,
  parameter int CNT_W    = $clog2(MAX_CNT + 1),
  parameter int LOCK_N   = 4,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int EQ_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_CNT);
  localparam logic [EQ_W-1:0]  EQ_LOCK  = EQ_W'(LOCK_N - 1);

  typedef enum logic [1:0] {IDLE, PH1, PH2, RUN} state_t;

  state_t           state;
  logic             sync_q1;
  logic             s;
  logic             s_filt;
  logic             s_prev;
  logic             rise;
  logic             fall;
  logic             edge_det;
  logic [CNT_W-1:0] ph_cnt;
  logic [EQ_W-1:0]  eq_cnt;
  logic [EQ_W-1:0]  eq_next;
  logic [CNT_W:0]   per_rise;
  logic [CNT_W:0]   per_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      s       <= 1'b0;
    end else begin
      sync_q1 <= sig_in;
      s       <= sync_q1;
    end
  end

`ifdef CLK_MEAS_FILTER_EN
  // The window is the current sample plus the FILT_LEN-1 previous ones; the
  // filtered level only moves once the whole window agrees.
  logic [FILT_LEN-2:0] filt_sr;
  logic [FILT_LEN-1:0] filt_win;

  assign filt_win = {filt_sr, s};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_sr <= '0;
      s_filt  <= 1'b0;
    end else begin
      filt_sr <= filt_win[FILT_LEN-2:0];
      if (&filt_win) begin
        s_filt <= 1'b1;
      end else if (~|filt_win) begin
        s_filt <= 1'b0;
      end
    end
  end
`else
  assign s_filt = s;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_prev <= 1'b0;
    end else begin
      s_prev <= s_filt;
    end
  end

  assign rise     = s_filt & ~s_prev;
  assign fall     = ~s_filt & s_prev;
  assign edge_det = rise | fall;

  // Period candidates using the phase closing in this cycle.
  assign per_fall = {1'b0, ph_cnt} + {1'b0, low_cnt};
  assign per_rise = {1'b0, high_cnt} + {1'b0, ph_cnt};

  always_comb begin
    eq_next = '0;
    if (per_rise == period) begin
      eq_next = (eq_cnt == EQ_LOCK) ? eq_cnt : eq_cnt + EQ_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ph_cnt     <= '0;
      eq_cnt     <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      // An edge in the saturation cycle wins over the timeout.
      if (edge_det) begin
        ph_cnt  <= CNT_W'(1);
        timeout <= 1'b0;
      end else if (ph_cnt == CNT_SAT) begin
        timeout <= 1'b1;
        locked  <= 1'b0;
        eq_cnt  <= '0;
        state   <= IDLE;
      end else begin
        ph_cnt <= ph_cnt + CNT_W'(1);
      end

      if (edge_det) begin
        case (state)
          IDLE: state <= PH1;
          PH1: begin
            if (fall) high_cnt <= ph_cnt;
            else      low_cnt  <= ph_cnt;
            state <= PH2;
          end
          PH2: begin
            if (fall) begin
              high_cnt <= ph_cnt;
              period   <= per_fall;
            end else begin
              low_cnt  <= ph_cnt;
              period   <= per_rise;
            end
            // First period after IDLE has nothing to compare against.
            meas_valid <= 1'b1;
            eq_cnt     <= '0;
            locked     <= 1'b0;
            state      <= RUN;
          end
          RUN: begin
            if (fall) begin
              high_cnt <= ph_cnt;
            end else begin
              low_cnt    <= ph_cnt;
              period     <= per_rise;
              meas_valid <= 1'b1;
              eq_cnt     <= eq_next;
              locked     <= (eq_next == EQ_LOCK);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
